btn_input_conditioner: RTL

Front-end conditioning for the five raw push-buttons (up, left, middle, right, down) of the range-hood controller. Each button is synchronised, debounced and edge-detected. The block then presents clean levels and single-cycle press, release and long-press pulses. Those pulses feed the page/button combining logic, which drives the on/off, mode, menu, time-adjust and gesture controls. It sits between the board pins and every control FSM, so no downstream block sees raw button inputs.

---
 rtl/btn_input_conditioner_pkg.sv | 19 +
 rtl/btn_input_conditioner_if.sv | 28 ++
 rtl/btn_input_conditioner_channel.sv | 101 ++++++++++
 rtl/btn_input_conditioner.sv | 39 +++
 4 files changed

// File: rtl/btn_input_conditioner_pkg.sv
// Shared constants and types for the push-button input conditioner.
// Button indices follow the board bit order {down, right, middle, left, up}.
package btn_input_conditioner_pkg;

  localparam int NUM_BTN    = 5;

  localparam int BTN_UP     = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_MIDDLE = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_DOWN   = 4;

  // 20 ms debounce and 3 s long-press at a 100 MHz system clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 2_000_000;
  localparam int DEFAULT_LONG_CYCLES     = 300_000_000;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

endpackage

// File: rtl/btn_input_conditioner_if.sv
// Button bundle between the board pins and the control logic.
// The slave side is the conditioner; the master side drives the raw pins.
interface btn_input_conditioner_if;
  import btn_input_conditioner_pkg::*;

  btn_vec_t btn_raw;
  btn_vec_t btn_level;
  btn_vec_t btn_press;
  btn_vec_t btn_release;
  btn_vec_t btn_long;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );

endinterface

// File: rtl/btn_input_conditioner_channel.sv
// One button: 2-flop synchroniser, debounce counter, press/release pulses and,
// when LONG_PRESS_EN is defined, a saturating hold counter for the long-press pulse.
module btn_channel #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int LONG_CYCLES     = 300_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int             DW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]  DMAX = DW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          stable_q, stable_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  always_comb begin
    s1_d      = btn_raw;
    s2_d      = s1_q;
    stable_d  = stable_q;
    dcnt_d    = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    // Any sample matching the accepted state restarts the count.
    if (s2_q != stable_q) begin
      if (dcnt_q == DMAX) begin
        stable_d  = s2_q;
        press_d   = s2_q;
        release_d = ~s2_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      stable_q  <= 1'b0;
      dcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stable_q  <= stable_d;
      dcnt_q    <= dcnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = stable_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef LONG_PRESS_EN
  localparam int            HW    = $clog2(LONG_CYCLES);
  localparam logic [HW-1:0] HMAX  = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HFIRE = HW'(LONG_CYCLES - 2);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          long_q, long_d;

  // Saturation at HMAX means HFIRE is passed only once per press.
  always_comb begin
    hcnt_d = '0;
    long_d = 1'b0;
    if (stable_q) begin
      hcnt_d = (hcnt_q == HMAX) ? hcnt_q : hcnt_q + 1'b1;
      long_d = (hcnt_q == HFIRE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      long_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      long_q <= long_d;
    end
  end

  assign btn_long = long_q;
`else
  // Constant 0; the parameter stays referenced so both builds share one port list.
  assign btn_long = 1'b0 & (LONG_CYCLES >= 2);
`endif

endmodule

// File: rtl/btn_input_conditioner.sv
// Five independent button channels behind one interface port.
// Optional long-press hold counters are built when LONG_PRESS_EN is defined.
module btn_input_conditioner
  import btn_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  btn_input_conditioner_if.slave   bus
);

  btn_vec_t level_w;
  btn_vec_t press_w;
  btn_vec_t release_w;
  btn_vec_t long_w;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_channel (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (bus.btn_raw[gi]),
      .btn_level   (level_w[gi]),
      .btn_press   (press_w[gi]),
      .btn_release (release_w[gi]),
      .btn_long    (long_w[gi])
    );
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;
  assign bus.btn_long    = long_w;

endmodule
